// File: rtl/wb_queue.sv
// Writeback queue: buffers ALU and MEM results in program order, retires one per cycle
// onto the single GPR write port, and forwards pending values to decode.
module wb_queue #(
    parameter int unsigned REG_FILE_BITS = 5,
    parameter int unsigned REG_SIZE      = 64,
    parameter int unsigned DEPTH         = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [REG_FILE_BITS-1:0]   mem_rd,
    input  logic [REG_SIZE-1:0]        mem_data,
    input  logic                       alu_valid,
    output logic                       alu_ready,
    input  logic [REG_FILE_BITS-1:0]   alu_rd,
    input  logic [REG_SIZE-1:0]        alu_data,
    output logic                       rf_we,
    output logic [REG_FILE_BITS-1:0]   rf_write_num,
    output logic [REG_SIZE-1:0]        rf_input_data,
    input  logic [REG_FILE_BITS-1:0]   fwd_num1,
    output logic                       fwd_hit1,
    output logic [REG_SIZE-1:0]        fwd_data1,
    input  logic [REG_FILE_BITS-1:0]   fwd_num2,
    output logic                       fwd_hit2,
    output logic [REG_SIZE-1:0]        fwd_data2,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    typedef struct packed {
        logic [REG_FILE_BITS-1:0] rd;
        logic [REG_SIZE-1:0]      data;
    } entry_t;

    entry_t             slots [DEPTH];
    logic [DEPTH-1:0]   valid;
    logic [DEPTH-1:0]   valid_next;
    logic [PTR_W-1:0]   rd_ptr;
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   alu_slot;
    logic [PTR_W-1:0]   scan_slot;
    logic               mem_push;
    logic               alu_push;
    logic               pop;

    // Ready looks only at registered occupancy plus the same-cycle MEM push; rd==0 is always sunk.
    always_comb begin
        mem_ready = (mem_rd == '0) || (count < CNT_W'(DEPTH));
        mem_push  = mem_valid && mem_ready && (mem_rd != '0);
        alu_ready = (alu_rd == '0) || ((count + CNT_W'(mem_push)) < CNT_W'(DEPTH));
        alu_push  = alu_valid && alu_ready && (alu_rd != '0);
        alu_slot  = wr_ptr + PTR_W'(mem_push);
        pop       = (count != '0);
    end

    // Head drives the register file write port; zeros when empty.
    always_comb begin
        rf_we         = pop;
        rf_write_num  = '0;
        rf_input_data = '0;
        if (pop) begin
            rf_write_num  = slots[rd_ptr].rd;
            rf_input_data = slots[rd_ptr].data;
        end
    end

    always_comb begin
        valid_next = valid;
        if (pop) begin
            valid_next[rd_ptr] = 1'b0;
        end
        if (mem_push) begin
            valid_next[wr_ptr] = 1'b1;
        end
        if (alu_push) begin
            valid_next[alu_slot] = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count  <= '0;
            rd_ptr <= '0;
            wr_ptr <= '0;
            valid  <= '0;
        end else begin
            count  <= count + CNT_W'(mem_push) + CNT_W'(alu_push) - CNT_W'(pop);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            wr_ptr <= wr_ptr + PTR_W'(mem_push) + PTR_W'(alu_push);
            valid  <= valid_next;
        end
    end

    // Payload storage carries no reset; valid bits qualify every read.
    always_ff @(posedge clk) begin
        if (mem_push) begin
            slots[wr_ptr] <= '{rd: mem_rd, data: mem_data};
        end
        if (alu_push) begin
            slots[alu_slot] <= '{rd: alu_rd, data: alu_data};
        end
    end

    // Walk oldest to youngest so the last match (youngest) wins; head stays visible until popped.
    always_comb begin
        fwd_hit1  = 1'b0;
        fwd_data1 = '0;
        fwd_hit2  = 1'b0;
        fwd_data2 = '0;
        scan_slot = '0;
        for (int unsigned k = 0; k < DEPTH; k++) begin
            scan_slot = rd_ptr + PTR_W'(k);
            if (valid[scan_slot] && (fwd_num1 != '0) && (slots[scan_slot].rd == fwd_num1)) begin
                fwd_hit1  = 1'b1;
                fwd_data1 = slots[scan_slot].data;
            end
            if (valid[scan_slot] && (fwd_num2 != '0) && (slots[scan_slot].rd == fwd_num2)) begin
                fwd_hit2  = 1'b1;
                fwd_data2 = slots[scan_slot].data;
            end
        end
    end

endmodule

// File: tb/tb_wb_queue.sv
// Directed and randomized checks of wb_queue against hand-computed values and a queue/regfile model.
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst;
    logic        mem_valid, mem_ready, alu_valid, alu_ready;
    logic [4:0]  mem_rd, alu_rd, rf_write_num, fwd_num1, fwd_num2;
    logic [63:0] mem_data, alu_data, rf_input_data, fwd_data1, fwd_data2;
    logic        rf_we, fwd_hit1, fwd_hit2;
    logic [2:0]  count;

    int checks = 0;
    int errors = 0;

    logic [63:0] tb_rf    [32];
    logic [63:0] model_rf [32];
    logic [4:0]  q_rd  [$];
    logic [63:0] q_dat [$];

    wb_queue dut (
        .clk(clk), .rst(rst),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
        .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
        .rf_we(rf_we), .rf_write_num(rf_write_num), .rf_input_data(rf_input_data),
        .fwd_num1(fwd_num1), .fwd_hit1(fwd_hit1), .fwd_data1(fwd_data1),
        .fwd_num2(fwd_num2), .fwd_hit2(fwd_hit2), .fwd_data2(fwd_data2),
        .count(count)
    );

    always #5 clk = ~clk;

    // Register file captures on the falling edge.
    always @(negedge clk) begin
        if (rf_we) tb_rf[rf_write_num] <= rf_input_data;
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        mem_valid = 1'b0; mem_rd = '0; mem_data = '0;
        alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    endtask

    task automatic push_mem(input logic [4:0] r, input logic [63:0] d);
        mem_valid = 1'b1; mem_rd = r; mem_data = d;
    endtask

    task automatic push_alu(input logic [4:0] r, input logic [63:0] d);
        alu_valid = 1'b1; alu_rd = r; alu_data = d;
    endtask

    function automatic logic [4:0] rdk(input int k);
        return 5'(k + 1);
    endfunction

    function automatic logic [63:0] datk(input int k);
        return 64'h1000 + 64'(k);
    endfunction

    function automatic logic [64:0] mfwd(input logic [4:0] n);
        logic [64:0] r;
        r = '0;
        if (n != '0) begin
            for (int i = 0; i < q_rd.size(); i++) begin
                if (q_rd[i] == n) r = {1'b1, q_dat[i]};
            end
        end
        return r;
    endfunction

    // One randomized cycle checked against the model, then the model advances.
    task automatic rand_step(input bit quiet);
        int  m_cnt;
        bit  e_mr, e_ar, mp, ap, e_we;
        logic [4:0]  e_num;
        logic [63:0] e_dat;
        if (quiet) begin
            idle_inputs();
        end else begin
            mem_valid = 1'($urandom_range(0, 1));
            mem_rd    = 5'($urandom_range(0, 15));
            mem_data  = {$urandom, $urandom};
            alu_valid = 1'($urandom_range(0, 1));
            alu_rd    = 5'($urandom_range(0, 15));
            alu_data  = {$urandom, $urandom};
        end
        fwd_num1 = 5'($urandom_range(0, 15));
        fwd_num2 = 5'($urandom_range(0, 15));
        #1;
        m_cnt = q_rd.size();
        e_mr  = (mem_rd == '0) || (m_cnt < 4);
        mp    = mem_valid && e_mr && (mem_rd != '0);
        e_ar  = (alu_rd == '0) || ((m_cnt + int'(mp)) < 4);
        ap    = alu_valid && e_ar && (alu_rd != '0);
        e_we  = (m_cnt != 0);
        e_num = e_we ? q_rd[0] : 5'd0;
        e_dat = e_we ? q_dat[0] : 64'd0;
        chk("rnd_ctl", {mem_ready, alu_ready, rf_we, rf_write_num, count},
            {e_mr, e_ar, e_we, e_num, 3'(m_cnt)});
        chk("rnd_data", rf_input_data, e_dat);
        chk("rnd_fwd1", {fwd_hit1, fwd_data1}, mfwd(fwd_num1));
        chk("rnd_fwd2", {fwd_hit2, fwd_data2}, mfwd(fwd_num2));
        chk("rnd_cnt_bound", 128'(count <= 3'd4), 128'd1);
        tick();
        if (e_we) begin
            model_rf[q_rd[0]] = q_dat[0];
            void'(q_rd.pop_front());
            void'(q_dat.pop_front());
        end
        if (mp) begin q_rd.push_back(mem_rd); q_dat.push_back(mem_data); end
        if (ap) begin q_rd.push_back(alu_rd); q_dat.push_back(alu_data); end
    endtask

    // Fill/drain table: item indices in acceptance order; -1 = channel idle.
    bit tm_v  [11] = '{1, 1, 1, 0, 1, 0, 1, 0, 1, 0, 1};
    int tm_k  [11] = '{0, 2, 4, -1, 6, -1, 8, -1, 10, -1, 12};
    bit ta_v  [11] = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    int ta_k  [11] = '{1, 3, 5, 5, 7, 7, 9, 9, 11, 11, -1};
    bit t_ar  [11] = '{1, 1, 0, 1, 0, 1, 0, 1, 0, 1, 1};
    int t_cnt [11] = '{0, 2, 3, 3, 3, 3, 3, 3, 3, 3, 3};
    int ret = 0;

    task automatic retire_check();
        if (rf_we === 1'b1) begin
            chk("t4_num", rf_write_num, rdk(ret));
            chk("t4_data", rf_input_data, datk(ret));
            ret++;
        end
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        fwd_num1 = 5'd5;
        fwd_num2 = 5'd0;
        #2;
        chk("rst_ctl", {mem_ready, alu_ready, rf_we, count}, {1'b1, 1'b1, 1'b0, 3'd0});
        chk("rst_fwd", {fwd_hit1, fwd_hit2, rf_write_num}, 7'd0);
        repeat (2) tick();
        rst = 1'b0;
        #1;
        chk("post_rst_ctl", {mem_ready, alu_ready, rf_we, count}, {1'b1, 1'b1, 1'b0, 3'd0});

        // Reset mid-stream with three entries queued
        push_mem(5'd1, 64'h11); push_alu(5'd2, 64'h22);
        tick();
        push_mem(5'd3, 64'h33); push_alu(5'd4, 64'h44);
        tick();
        idle_inputs();
        fwd_num1 = 5'd4;
        #1;
        chk("t1_count3", count, 3'd3);
        chk("t1_head", {rf_we, rf_write_num, rf_input_data}, {1'b1, 5'd2, 64'h22});
        chk("t1_fwd", {fwd_hit1, fwd_data1}, {1'b1, 64'h44});
        #1;
        rst = 1'b1;
        #1;
        chk("t1_rst_now", {rf_we, count, fwd_hit1}, {1'b0, 3'd0, 1'b0});
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("t1_no_write", {rf_we, count}, {1'b0, 3'd0});
            tick();
        end
        chk("t1_first_written", tb_rf[1], 64'h11);

        // Single ALU push and its one-cycle latency
        fwd_num1 = 5'd5;
        push_alu(5'd5, 64'h1234);
        #1;
        chk("t2_ready", {mem_ready, alu_ready}, 2'b11);
        tick();
        idle_inputs();
        #1;
        chk("t2_write", {rf_we, rf_write_num, rf_input_data}, {1'b1, 5'd5, 64'h1234});
        chk("t2_count1", count, 3'd1);
        chk("t2_fwd", {fwd_hit1, fwd_data1}, {1'b1, 64'h1234});
        tick();
        chk("t2_empty", {rf_we, rf_write_num, rf_input_data, count}, {1'b0, 5'd0, 64'd0, 3'd0});
        chk("t2_fwd_gone", {fwd_hit1, fwd_data1}, 65'd0);
        tick();
        chk("t2_count_n2", count, 3'd0);
        chk("t2_rf5", tb_rf[5], 64'h1234);

        // Same destination from both channels in one cycle: MEM is older
        fwd_num1 = 5'd3;
        push_mem(5'd3, 64'hAA); push_alu(5'd3, 64'hBB);
        #1;
        chk("t3_no_fwd_incoming", fwd_hit1, 1'b0);
        tick();
        idle_inputs();
        #1;
        chk("t3_first", {rf_we, rf_write_num, rf_input_data, count}, {1'b1, 5'd3, 64'hAA, 3'd2});
        chk("t3_fwd_young", {fwd_hit1, fwd_data1}, {1'b1, 64'hBB});
        tick();
        chk("t3_second", {rf_we, rf_write_num, rf_input_data, count}, {1'b1, 5'd3, 64'hBB, 3'd1});
        chk("t3_fwd_head", {fwd_hit1, fwd_data1}, {1'b1, 64'hBB});
        chk("t3_rf_aa", tb_rf[3], 64'hAA);
        tick();
        chk("t3_drained", {fwd_hit1, count}, {1'b0, 3'd0});
        chk("t3_rf_bb", tb_rf[3], 64'hBB);

        // Fill under continuous drain, ALU backpressure, wrap, and an rd==0 ALU request
        fwd_num2 = 5'd0;
        for (int c = 0; c < 11; c++) begin
            idle_inputs();
            if (tm_v[c]) push_mem(rdk(tm_k[c]), datk(tm_k[c]));
            if (ta_v[c]) begin
                if (ta_k[c] < 0) push_alu(5'd0, 64'hDEAD);
                else push_alu(rdk(ta_k[c]), datk(ta_k[c]));
            end
            #1;
            chk("t4_count", count, 3'(t_cnt[c]));
            chk("t4_ready", {mem_ready, alu_ready}, {1'b1, t_ar[c]});
            if (c == 10) chk("t5_fwd_zero", {fwd_hit2, fwd_data2}, 65'd0);
            retire_check();
            tick();
        end
        idle_inputs();
        for (int i = 0; i < 5; i++) begin
            #1;
            retire_check();
            tick();
        end
        chk("t4_retired", 128'(ret), 128'd13);
        chk("t4_final_count", count, 3'd0);

        // Randomized run against queue + regfile model
        for (int r = 0; r < 32; r++) model_rf[r] = tb_rf[r];
        for (int cyc = 0; cyc < 10000; cyc++) rand_step(1'b0);
        for (int cyc = 0; cyc < 6; cyc++) rand_step(1'b1);
        for (int r = 0; r < 32; r++) chk("rnd_gpr", tb_rf[r], model_rf[r]);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
